requant_out: RTL and testbench

REQUANT_OUT -- requirements
Module: requant_out

---
 rtl/requant_out_pkg.sv | 15 +
 rtl/requant_out_if.sv | 32 +++
 rtl/regn.sv | 24 ++
 rtl/satn.sv | 26 ++
 rtl/requant_out.sv | 107 ++++++++++
 tb/tb_requant_out.sv | 304 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/requant_out_pkg.sv
// Shared datapath constants for the requantization output stage.
package requant_out_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_AWIDTH = 32;
    localparam int DEF_MWIDTH = 16;
    localparam int DEF_SWIDTH = 6;
    localparam int DEF_PWIDTH = DEF_AWIDTH + DEF_MWIDTH + 2;

    // Product width: biased accumulator (AWIDTH+1) times zero-extended scale (MWIDTH+1).
    function automatic int pwidth(input int aw, input int mw);
        return aw + mw + 2;
    endfunction

endpackage

// File: rtl/requant_out_if.sv
// Beat-level handshake bundle between the accumulator source, requant_out and its sink.
interface requant_out_if
    import requant_out_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int MWIDTH = DEF_MWIDTH,
    parameter int SWIDTH = DEF_SWIDTH
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [AWIDTH-1:0] in_acc;
    logic signed [AWIDTH-1:0] bias;
    logic        [MWIDTH-1:0] scale;
    logic        [SWIDTH-1:0] shift;
    logic                     relu_en;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out_data;

    modport master (
        output in_valid, in_acc, bias, scale, shift, relu_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_acc, bias, scale, shift, relu_en, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/regn.sv
// Library enable register with synchronous clear; clear wins over enable.
module regn #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/satn.sv
// Signed clamp from IW bits to OW bits, flagging when the value was out of range.
module satn #(
    parameter int IW = 50,
    parameter int OW = 8
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 sat
);

    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = ~MAXV;

    always_comb begin
        dout = din[OW-1:0];
        sat  = 1'b0;
        if (din > MAXV) begin
            dout = {1'b0, {(OW-1){1'b1}}};
            sat  = 1'b1;
        end else if (din < MINV) begin
            dout = {1'b1, {(OW-1){1'b0}}};
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/requant_out.sv
// Three-stage requantizer: bias add, scale multiply, round/shift/ReLU/clamp,
// with an elastic valid/ready pipeline and a saturation event counter.
module requant_out
    import requant_out_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int MWIDTH = DEF_MWIDTH,
    parameter int SWIDTH = DEF_SWIDTH
) (
    input  logic         clk,
    input  logic         clr,
    requant_out_if.slave bus,
    output logic [15:0]  sat_cnt
);

    localparam int PWIDTH = pwidth(AWIDTH, MWIDTH);
    localparam int CW1    = MWIDTH + SWIDTH + 1;
    localparam int CW2    = SWIDTH + 1;

    // Round half toward +inf, then arithmetic shift; oversized shifts collapse to the sign.
    function automatic logic signed [PWIDTH-1:0] round_shift(
        input logic signed [PWIDTH-1:0] p,
        input logic        [SWIDTH-1:0] sh
    );
        logic signed [PWIDTH-1:0] half;
        logic signed [PWIDTH-1:0] sum;
        if (int'(sh) >= PWIDTH) begin
            return {PWIDTH{p[PWIDTH-1]}};
        end
        half = (sh == '0) ? '0 : (PWIDTH'(1) << (sh - SWIDTH'(1)));
        sum  = p + half;
        return sum >>> sh;
    endfunction

    logic                     ld_p1, ld_p2, ld_p3;
    logic                     vld_p1_q, vld_p2_q, vld_p3_q;
    logic signed [AWIDTH:0]   s1_p1_d, s1_p1_q;
    logic [CW1-1:0]           ctl_p1_q;
    logic [MWIDTH-1:0]        scale_p1;
    logic [SWIDTH-1:0]        shift_p1, shift_p2;
    logic                     relu_p1, relu_p2;
    logic signed [PWIDTH-1:0] prod_p2_d, prod_p2_q;
    logic [CW2-1:0]           ctl_p2_q;
    logic signed [PWIDTH-1:0] rnd_p2, relu_out_p2;
    logic signed [DWIDTH-1:0] sat_out_p2, out_p3_q;
    logic                     sat_flag_p2;
    logic [15:0]              sat_cnt_q, sat_cnt_d;

    assign ld_p3        = !vld_p3_q || bus.out_ready;
    assign ld_p2        = !vld_p2_q || ld_p3;
    assign ld_p1        = !vld_p1_q || ld_p2;
    assign bus.in_ready = ld_p1;

    // ---- S1: bias add, sideband captured with the beat ----
    assign s1_p1_d = (AWIDTH+1)'(bus.in_acc) + (AWIDTH+1)'(bus.bias);

    regn #(.W(1))        u_vld_p1 (.clk(clk), .clr(clr), .en(ld_p1), .d(bus.in_valid), .q(vld_p1_q));
    regn #(.W(AWIDTH+1)) u_s1_p1  (.clk(clk), .clr(clr), .en(ld_p1), .d(s1_p1_d),      .q(s1_p1_q));
    regn #(.W(CW1))      u_ctl_p1 (.clk(clk), .clr(clr), .en(ld_p1),
                                   .d({bus.scale, bus.shift, bus.relu_en}), .q(ctl_p1_q));

    assign {scale_p1, shift_p1, relu_p1} = ctl_p1_q;

    // ---- S2: scale multiply ----
    assign prod_p2_d = PWIDTH'(s1_p1_q) * PWIDTH'($signed({1'b0, scale_p1}));

    regn #(.W(1))      u_vld_p2  (.clk(clk), .clr(clr), .en(ld_p2), .d(vld_p1_q),            .q(vld_p2_q));
    regn #(.W(PWIDTH)) u_prod_p2 (.clk(clk), .clr(clr), .en(ld_p2), .d(prod_p2_d),           .q(prod_p2_q));
    regn #(.W(CW2))    u_ctl_p2  (.clk(clk), .clr(clr), .en(ld_p2), .d({shift_p1, relu_p1}), .q(ctl_p2_q));

    assign {shift_p2, relu_p2} = ctl_p2_q;

    // ---- S3: round, ReLU, clamp into the output register ----
    assign rnd_p2      = round_shift(prod_p2_q, shift_p2);
    assign relu_out_p2 = (relu_p2 && rnd_p2[PWIDTH-1]) ? '0 : rnd_p2;

    satn #(.IW(PWIDTH), .OW(DWIDTH)) u_satn (
        .din  (relu_out_p2),
        .dout (sat_out_p2),
        .sat  (sat_flag_p2)
    );

    regn #(.W(1))      u_vld_p3 (.clk(clk), .clr(clr), .en(ld_p3), .d(vld_p2_q),   .q(vld_p3_q));
    regn #(.W(DWIDTH)) u_out_p3 (.clk(clk), .clr(clr), .en(ld_p3), .d(sat_out_p2), .q(out_p3_q));

    assign bus.out_valid = vld_p3_q;
    assign bus.out_data  = out_p3_q;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (ld_p3 && vld_p2_q && sat_flag_p2 && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_requant_out.sv
// Self-checking bench for requant_out: directed scenarios plus a randomized stream
// scored against an arithmetic reference model.
module tb_requant_out;

    localparam int PW = 32 + 16 + 2;

    logic        clk;
    logic        clr;
    logic [15:0] sat_cnt;
    int          n_pass;
    int          n_total;

    requant_out_if bif ();

    requant_out u_dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bif.slave),
        .sat_cnt (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_requant(input longint acc, input longint bias, input longint scale,
                                       input int sh, input bit relu, output bit sat);
        longint s1, p, d, sum, r;
        s1 = acc + bias;
        p  = s1 * scale;
        if (sh >= PW) begin
            r = (p < 0) ? -1 : 0;
        end else begin
            d   = longint'(1) << sh;
            sum = p + ((sh > 0) ? d / 2 : 0);
            r   = sum / d;
            if ((sum % d != 0) && (sum < 0)) r = r - 1;
        end
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 127) begin
            r = 127; sat = 1'b1;
        end else if (r < -128) begin
            r = -128; sat = 1'b1;
        end
        return int'(r);
    endfunction

    task automatic do_reset();
        clr = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic drive_beat(input int acc, input int bias, input int sc, input int sh, input bit rl);
        bif.in_acc  = acc;
        bif.bias    = bias;
        bif.scale   = 16'(sc);
        bif.shift   = 6'(sh);
        bif.relu_en = rl;
    endtask

    // Sends one beat with the sink ready and returns the emerging value (ok=0 on timeout).
    task automatic one_beat(input int acc, input int bias, input int sc, input int sh, input bit rl,
                            output int got, output bit ok);
        int n;
        ok = 1'b0;
        got = 0;
        drive_beat(acc, bias, sc, sh, rl);
        bif.in_valid = 1'b1;
        bif.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bif.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        n = 0;
        while (!bif.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (bif.out_valid) begin
            got = bif.out_data;
            ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (bif.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bif.out_valid); else n_pass++;
        n_total++; if (bif.out_data !== 8'sd0) $display("FAIL rst_out_data got %0d want 0", bif.out_data); else n_pass++;
        n_total++; if (sat_cnt !== 16'd0) $display("FAIL rst_sat_cnt got %0d want 0", sat_cnt); else n_pass++;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bif.in_ready); else n_pass++;
    endtask

    task automatic test_latency();
        int od;
        drive_beat(1000, 24, 1, 4, 1'b0);
        bif.in_valid = 1'b1;
        bif.out_ready = 1'b1;
        #1;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL lat_in_ready got %b want 1", bif.in_ready); else n_pass++;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        n_total++; if (bif.out_valid !== 1'b0) $display("FAIL lat_early1 out_valid got %b want 0", bif.out_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bif.out_valid !== 1'b0) $display("FAIL lat_early2 out_valid got %b want 0", bif.out_valid); else n_pass++;
        @(posedge clk); #1;
        od = bif.out_data;
        n_total++; if (bif.out_valid !== 1'b1) $display("FAIL lat_valid got %b want 1", bif.out_valid); else n_pass++;
        n_total++; if (od !== 64) $display("FAIL lat_data got %0d want 64", od); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bif.out_valid !== 1'b0) $display("FAIL lat_drained out_valid got %b want 0", bif.out_valid); else n_pass++;
    endtask

    task automatic test_rounding();
        int accs[3] = '{23, -21, -20};
        int exps[3] = '{3, -3, -2};
        int got;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            one_beat(accs[i], 0, 1, 3, 1'b0, got, ok);
            n_total++;
            if (!ok || got !== exps[i]) $display("FAIL round_acc%0d got %0d (ok=%0b) want %0d", accs[i], got, ok, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int got;
        bit ok;
        do_reset();
        one_beat(100000, 0, 1, 0, 1'b0, got, ok);
        n_total++; if (!ok || got !== 127) $display("FAIL sat_pos got %0d want 127", got); else n_pass++;
        n_total++; if (sat_cnt !== 16'd1) $display("FAIL sat_cnt_pos got %0d want 1", sat_cnt); else n_pass++;
        one_beat(-100000, 0, 1, 0, 1'b0, got, ok);
        n_total++; if (!ok || got !== -128) $display("FAIL sat_neg got %0d want -128", got); else n_pass++;
        n_total++; if (sat_cnt !== 16'd2) $display("FAIL sat_cnt_neg got %0d want 2", sat_cnt); else n_pass++;
        one_beat(-5, 0, 1, 0, 1'b1, got, ok);
        n_total++; if (!ok || got !== 0) $display("FAIL relu_zero got %0d want 0", got); else n_pass++;
        one_beat(-100000, 0, 1, 0, 1'b1, got, ok);
        n_total++; if (!ok || got !== 0) $display("FAIL relu_big_neg got %0d want 0", got); else n_pass++;
        n_total++; if (sat_cnt !== 16'd2) $display("FAIL sat_cnt_relu got %0d want 2", sat_cnt); else n_pass++;
    endtask

    task automatic test_shift_extremes();
        int got;
        bit ok;
        one_beat(-1, 0, 1, 63, 1'b0, got, ok);
        n_total++; if (!ok || got !== -1) $display("FAIL shift63_neg got %0d want -1", got); else n_pass++;
        one_beat(1, 0, 1, 63, 1'b0, got, ok);
        n_total++; if (!ok || got !== 0) $display("FAIL shift63_pos got %0d want 0", got); else n_pass++;
        one_beat(-3000, 0, 65535, 50, 1'b0, got, ok);
        n_total++; if (!ok || got !== -1) $display("FAIL shift50_neg got %0d want -1", got); else n_pass++;
    endtask

    task automatic test_backpressure();
        int sent, got, cyc, od;
        bit acc_now, out_now, hold;
        int hold_val;
        sent = 0; got = 0; cyc = 0; hold = 1'b0; hold_val = 0;
        drive_beat(0, 0, 1, 0, 1'b0);
        while (got < 8 && cyc < 200) begin
            if (cyc == 5) begin
                n_total++; if (sent !== 3) $display("FAIL bp_absorbed got %0d want 3", sent); else n_pass++;
                n_total++; if (bif.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", bif.in_ready); else n_pass++;
            end
            bif.out_ready = (cyc >= 5);
            bif.in_valid  = (sent < 8);
            bif.in_acc    = sent + 1;
            #1;
            od = bif.out_data;
            if (hold) begin
                n_total++;
                if (bif.out_valid !== 1'b1 || od !== hold_val) $display("FAIL bp_stable got %0d/%b want %0d/1", od, bif.out_valid, hold_val);
                else n_pass++;
            end
            acc_now  = bif.in_valid && bif.in_ready;
            out_now  = bif.out_valid && bif.out_ready;
            hold     = bif.out_valid && !bif.out_ready;
            hold_val = od;
            @(posedge clk); #1;
            if (acc_now) sent++;
            if (out_now) begin
                n_total++; if (od !== got + 1) $display("FAIL bp_order got %0d want %0d", od, got + 1); else n_pass++;
                got++;
            end
            cyc++;
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        n_total++; if (got !== 8) $display("FAIL bp_timeout got %0d beats want 8", got); else n_pass++;
    endtask

    task automatic test_clear();
        int got, seen;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) one_beat(100000, 0, 1, 0, 1'b0, got, ok);
        n_total++; if (sat_cnt !== 16'd5) $display("FAIL clr_pre_sat_cnt got %0d want 5", sat_cnt); else n_pass++;
        drive_beat(7, 0, 1, 0, 1'b0);
        bif.out_ready = 1'b0;
        bif.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bif.in_valid = 1'b0;
        n_total++; if (bif.out_valid !== 1'b0) $display("FAIL clr_out_valid got %b want 0", bif.out_valid); else n_pass++;
        n_total++; if (bif.out_data !== 8'sd0) $display("FAIL clr_out_data got %0d want 0", bif.out_data); else n_pass++;
        n_total++; if (sat_cnt !== 16'd0) $display("FAIL clr_sat_cnt got %0d want 0", sat_cnt); else n_pass++;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL clr_in_ready got %b want 1", bif.in_ready); else n_pass++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bif.out_valid) seen++;
            @(posedge clk); #1;
        end
        n_total++; if (seen !== 0) $display("FAIL clr_stale got %0d beats want 0", seen); else n_pass++;
        one_beat(9, 0, 1, 0, 1'b0, got, ok);
        n_total++; if (!ok || got !== 9) $display("FAIL clr_fresh got %0d want 9", got); else n_pass++;
    endtask

    task automatic test_random();
        localparam int N = 300;
        int  exp_q[$];
        bit  sat_q[$];
        int  sent, got, cyc, od, a, b, sc, sh, e, exp_sat, hold_val;
        bit  rl, s, acc_now, out_now, hold, es;
        do_reset();
        sent = 0; got = 0; cyc = 0; exp_sat = 0; hold = 1'b0; hold_val = 0;
        while (got < N && cyc < 5000) begin
            a  = int'($urandom) >>> 8;
            b  = int'($urandom) >>> 16;
            sc = int'($urandom_range(0, 65535));
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20));
            rl = $urandom_range(0, 1) == 1;
            drive_beat(a, b, sc, sh, rl);
            bif.in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            bif.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            od = bif.out_data;
            if (hold) begin
                n_total++;
                if (bif.out_valid !== 1'b1 || od !== hold_val) $display("FAIL rnd_stable got %0d/%b want %0d/1", od, bif.out_valid, hold_val);
                else n_pass++;
            end
            acc_now  = bif.in_valid && bif.in_ready;
            out_now  = bif.out_valid && bif.out_ready;
            hold     = bif.out_valid && !bif.out_ready;
            hold_val = od;
            if (acc_now) begin
                e = ref_requant(longint'(a), longint'(b), longint'(sc), sh, rl, s);
                exp_q.push_back(e);
                sat_q.push_back(s);
                sent++;
            end
            if (out_now) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rnd_unexpected got %0d want no beat", od);
                end else begin
                    e  = exp_q.pop_front();
                    es = sat_q.pop_front();
                    if (es && exp_sat < 65535) exp_sat++;
                    n_total++;
                    if (od !== e) $display("FAIL rnd_data beat %0d got %0d want %0d", got, od, e);
                    else n_pass++;
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        n_total++; if (got !== N) $display("FAIL rnd_timeout got %0d beats want %0d", got, N); else n_pass++;
        n_total++; if (sat_cnt !== 16'(exp_sat)) $display("FAIL rnd_sat_cnt got %0d want %0d", sat_cnt, exp_sat); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        clr = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        drive_beat(0, 0, 0, 0, 1'b0);
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_shift_extremes();
        test_backpressure();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
